rr_arbiter_wlock: RTL and testbench

//  N-input weighted round-robin arbiter with packet (wormhole) lock for router output ports.

---
 rtl/ravenoc_arb_pkg.sv | 34 +++
 rtl/rr_prio_enc.sv | 31 +++
 rtl/rr_arbiter_wlock.sv | 139 +++++++++++++
 tb/tb_rr_arbiter_wlock.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ravenoc_arb_pkg.sv
// Shared types and helpers for the weighted round-robin packet arbiter.
package ravenoc_arb_pkg;

    // IDLE arbitrates every cycle; LOCKED holds the output for one packet owner.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Widest requester vector the helpers handle; callers zero-extend into it.
    localparam int MAX_REQ = 32;

    // Index of the set bit of a one-hot vector (0 for an all-zero vector).
    function automatic logic [31:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [31:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | 32'(i);
            end
        end
        return idx;
    endfunction

    // Thermometer mask: bits >= idx when incl=1, bits strictly above idx when incl=0.
    function automatic logic [MAX_REQ-1:0] mask_above(input logic [31:0] idx, input logic incl);
        logic [MAX_REQ-1:0] m;
        for (int i = 0; i < MAX_REQ; i++) begin
            m[i] = incl ? (32'(i) >= idx) : (32'(i) > idx);
        end
        return m;
    endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Lowest-set-bit priority encoder: one-hot winner, its index and an any-request flag.
module rr_prio_enc
    import ravenoc_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // lower[i] is set when any request below bit i is active.
    logic [N:0] lower;

    assign lower[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_bit
            assign onehot[gi]    = req[gi] & ~lower[gi];
            assign lower[gi + 1] = lower[gi] | req[gi];
        end
    endgenerate

    assign any = lower[N];
    // N is limited to MAX_REQ by the helper width.
    assign idx = IDX_W'(onehot_to_idx(MAX_REQ'(onehot)));

endmodule

// File: rtl/rr_arbiter_wlock.sv
// Weighted round-robin arbiter with wormhole packet lock for a router output port.
// A requester keeps the output from its first accepted beat to its last, and may
// win up to WEIGHT consecutive packets before priority rotates past it.
module rr_arbiter_wlock
    import ravenoc_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int WEIGHT = 1,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [N_REQ-1:0] req_i,
    input  logic             update_i,
    input  logic             last_i,
    input  logic             fixed_prio_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             locked_o
);

    localparam int CNT_W = $clog2(WEIGHT + 1);
    localparam logic [CNT_W-1:0] WEIGHT_C = CNT_W'(WEIGHT);

    arb_state_t       state_reg, state_next;
    logic [IDX_W-1:0] lock_idx_reg, lock_idx_next;
    logic [IDX_W-1:0] owner_reg, owner_next;
    logic [CNT_W-1:0] pkt_cnt_reg, pkt_cnt_next;
    logic [N_REQ-1:0] mask_reg, mask_next;

    logic [N_REQ-1:0] masked_req;
    logic [N_REQ-1:0] m_oh, r_oh;
    logic [IDX_W-1:0] m_idx, r_idx;
    logic             m_any, r_any;
    logic [N_REQ-1:0] lock_oh;

    logic             accept;
    logic             complete;
    logic [CNT_W-1:0] cmp_cnt;
    logic             rotate;
    logic [N_REQ-1:0] cmp_mask;

    assign masked_req = req_i & mask_reg;
    assign lock_oh    = N_REQ'(1) << lock_idx_reg;

    rr_prio_enc #(.N(N_REQ), .IDX_W(IDX_W)) u_enc_masked (
        .req    (masked_req),
        .onehot (m_oh),
        .idx    (m_idx),
        .any    (m_any)
    );

    rr_prio_enc #(.N(N_REQ), .IDX_W(IDX_W)) u_enc_raw (
        .req    (req_i),
        .onehot (r_oh),
        .idx    (r_idx),
        .any    (r_any)
    );

    // A beat only counts when someone actually holds the grant.
    assign accept   = update_i & (|grant_o);
    assign complete = accept & last_i;
    assign locked_o = (state_reg == LOCKED);

    // State register; asynchronous reset drops any lock immediately.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: enter LOCKED on a non-final accepted beat, leave on the final one.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept && !last_i) state_next = LOCKED;
            LOCKED:  if (complete)          state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grant output: locked owner (while still requesting) or round-robin / fixed pick.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        if (state_reg == LOCKED) begin
            if (req_i[lock_idx_reg]) begin
                grant_o     = lock_oh;
                grant_idx_o = lock_idx_reg;
            end
        end else if (fixed_prio_i || !m_any) begin
            // Empty masked set falls back to the lowest raw request (wrap-around).
            grant_o     = r_oh;
            grant_idx_o = r_any ? r_idx : '0;
        end else begin
            grant_o     = m_oh;
            grant_idx_o = m_idx;
        end
    end

    // Completion rule: count consecutive packets of the same owner, rotate at WEIGHT.
    always_comb begin
        cmp_cnt  = (grant_idx_o != owner_reg) ? CNT_W'(1) : pkt_cnt_reg + CNT_W'(1);
        rotate   = (cmp_cnt == WEIGHT_C);
        cmp_mask = N_REQ'(mask_above(32'(grant_idx_o), !rotate));

        mask_next     = mask_reg;
        pkt_cnt_next  = pkt_cnt_reg;
        owner_next    = owner_reg;
        lock_idx_next = lock_idx_reg;

        if (complete) begin
            mask_next    = cmp_mask;
            pkt_cnt_next = rotate ? '0 : cmp_cnt;
            owner_next   = grant_idx_o;
        end
        if ((state_reg == IDLE) && accept && !last_i) begin
            lock_idx_next = grant_idx_o;
        end
    end

    // Arbitration bookkeeping registers.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            mask_reg     <= '1;
            lock_idx_reg <= '0;
            owner_reg    <= '0;
            pkt_cnt_reg  <= '0;
        end else begin
            mask_reg     <= mask_next;
            lock_idx_reg <= lock_idx_next;
            owner_reg    <= owner_next;
            pkt_cnt_reg  <= pkt_cnt_next;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_wlock.sv
// Self-checking bench: directed vector table, hand sequences, and random
// stimulus against a pointer-based round-robin reference model.
module tb_rr_arbiter_wlock;

    logic       clk;
    logic       arst;
    logic [3:0] req;
    logic       upd;
    logic       last;
    logic       fix;

    logic [3:0] g1, g2;
    logic [1:0] gi1, gi2;
    logic       l1, l2;

    int tests_run    = 0;
    int tests_failed = 0;

    rr_arbiter_wlock #(.N_REQ(4), .WEIGHT(1)) dut1 (
        .clk          (clk),
        .arst         (arst),
        .req_i        (req),
        .update_i     (upd),
        .last_i       (last),
        .fixed_prio_i (fix),
        .grant_o      (g1),
        .grant_idx_o  (gi1),
        .locked_o     (l1)
    );

    rr_arbiter_wlock #(.N_REQ(4), .WEIGHT(2)) dut2 (
        .clk          (clk),
        .arst         (arst),
        .req_i        (req),
        .update_i     (upd),
        .last_i       (last),
        .fixed_prio_i (fix),
        .grant_o      (g2),
        .grant_idx_o  (gi2),
        .locked_o     (l2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic int oh_idx(input logic [3:0] oh);
        for (int i = 0; i < 4; i++) if (oh[i]) return i;
        return 0;
    endfunction

    // ---------------- reference model ----------------
    // ptr = first index with priority (N means none -> lowest wins).
    int m_weight [2] = '{1, 2};
    int m_ptr    [2];
    int m_owner  [2];
    int m_cnt    [2];
    int m_lidx   [2];
    bit m_locked [2];

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ptr[k] = 0; m_owner[k] = 0; m_cnt[k] = 0; m_lidx[k] = 0; m_locked[k] = 0;
        end
    endfunction

    function automatic int model_grant(input int k, input logic [3:0] r, input logic f);
        if (m_locked[k]) return r[m_lidx[k]] ? m_lidx[k] : -1;
        if (!f) for (int i = m_ptr[k]; i < 4; i++) if (r[i]) return i;
        for (int i = 0; i < 4; i++) if (r[i]) return i;
        return -1;
    endfunction

    function automatic void model_complete(input int k, input int g);
        int c;
        if (g != m_owner[k]) begin
            m_owner[k] = g;
            c = 1;
        end else begin
            c = m_cnt[k] + 1;
        end
        if (c == m_weight[k]) begin
            m_ptr[k] = g + 1;
            m_cnt[k] = 0;
        end else begin
            m_ptr[k] = g;
            m_cnt[k] = c;
        end
    endfunction

    function automatic void model_step(input int k, input logic [3:0] r, input logic u,
                                       input logic ls, input logic f);
        int g;
        g = model_grant(k, r, f);
        if (u && g >= 0) begin
            if (!m_locked[k]) begin
                if (!ls) begin
                    m_locked[k] = 1;
                    m_lidx[k]   = g;
                end else begin
                    model_complete(k, g);
                end
            end else if (ls) begin
                m_locked[k] = 0;
                model_complete(k, g);
            end
        end
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         rst;
        int         which;
        logic [3:0] req;
        logic       upd;
        logic       last;
        logic       fix;
        logic [3:0] exp_g;
        logic       exp_l;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rs, input int w, input logic [3:0] r, input logic u,
                       input logic ls, input logic f, input logic [3:0] eg, input logic el);
        vec_t v;
        v.rst = rs; v.which = w; v.req = r; v.upd = u; v.last = ls; v.fix = f;
        v.exp_g = eg; v.exp_l = el;
        vecs.push_back(v);
    endtask

    task automatic pulse_reset();
        arst = 1'b0;
        #1;
        arst = 1'b1;
    endtask

    initial begin
        logic [3:0] ag;
        logic [1:0] ai;
        logic       al;
        int         e1, e2;

        // Reset state: grants are combinational and use the full mask.
        arst = 1'b0; req = 4'b1010; upd = 0; last = 0; fix = 0;
        #1;
        check("rst grant w1", 32'(g1), 32'(4'b0010));
        check("rst idx w1",   32'(gi1), 32'd1);
        check("rst lock w1",  32'(l1), 32'd0);
        check("rst grant w2", 32'(g2), 32'(4'b0010));
        check("rst lock w2",  32'(l2), 32'd0);
        @(negedge clk);
        arst = 1'b1;

        // Classic RR rotation with wrap.
        add(1, 0, 4'b1111, 1, 1, 0, 4'b0001, 0);
        add(0, 0, 4'b1111, 1, 1, 0, 4'b0010, 0);
        add(0, 0, 4'b1111, 1, 1, 0, 4'b0100, 0);
        add(0, 0, 4'b1111, 1, 1, 0, 4'b1000, 0);
        add(0, 0, 4'b1111, 1, 1, 0, 4'b0001, 0);
        // Multi-beat packet holds the lock, then rotates.
        add(1, 0, 4'b0011, 1, 0, 0, 4'b0001, 0);
        add(0, 0, 4'b0011, 1, 0, 0, 4'b0001, 1);
        add(0, 0, 4'b0011, 1, 0, 0, 4'b0001, 1);
        add(0, 0, 4'b0011, 1, 1, 0, 4'b0001, 1);
        add(0, 0, 4'b0011, 0, 0, 0, 4'b0010, 0);
        // WEIGHT=2: two packets per owner.
        add(1, 1, 4'b0101, 1, 1, 0, 4'b0001, 0);
        add(0, 1, 4'b0101, 1, 1, 0, 4'b0001, 0);
        add(0, 1, 4'b0101, 1, 1, 0, 4'b0100, 0);
        add(0, 1, 4'b0101, 1, 1, 0, 4'b0100, 0);
        add(0, 1, 4'b0101, 1, 1, 0, 4'b0001, 0);
        // Fixed priority keeps updating the mask.
        add(1, 0, 4'b1110, 1, 1, 1, 4'b0010, 0);
        add(0, 0, 4'b1110, 1, 1, 1, 4'b0010, 0);
        add(0, 0, 4'b1110, 1, 1, 1, 4'b0010, 0);
        add(0, 0, 4'b1110, 0, 0, 0, 4'b0100, 0);
        // update with no grant is ignored.
        add(1, 0, 4'b0000, 1, 0, 0, 4'b0000, 0);
        add(0, 0, 4'b0010, 0, 0, 0, 4'b0010, 0);
        // last without update is ignored.
        add(1, 0, 4'b0001, 0, 1, 0, 4'b0001, 0);
        add(0, 0, 4'b0011, 0, 0, 0, 4'b0001, 0);
        // Owner drops req mid-packet: keeps lock, no grant, update ignored; then wrap.
        add(1, 0, 4'b0100, 1, 0, 0, 4'b0100, 0);
        add(0, 0, 4'b0011, 1, 1, 0, 4'b0000, 1);
        add(0, 0, 4'b0111, 1, 1, 0, 4'b0100, 1);
        add(0, 0, 4'b0111, 0, 0, 0, 4'b0001, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            if (vecs[i].rst) pulse_reset();
            req = vecs[i].req; upd = vecs[i].upd; last = vecs[i].last; fix = vecs[i].fix;
            #1;
            ag = (vecs[i].which == 0) ? g1  : g2;
            ai = (vecs[i].which == 0) ? gi1 : gi2;
            al = (vecs[i].which == 0) ? l1  : l2;
            check($sformatf("vec%0d grant", i), 32'(ag), 32'(vecs[i].exp_g));
            check($sformatf("vec%0d idx", i),   32'(ai), 32'(oh_idx(vecs[i].exp_g)));
            check($sformatf("vec%0d lock", i),  32'(al), 32'(vecs[i].exp_l));
            $display("[TB] vec%0d req=%b upd=%b last=%b fix=%b grant=%b locked=%b",
                     i, vecs[i].req, vecs[i].upd, vecs[i].last, vecs[i].fix, ag, al);
        end

        // Asynchronous reset while locked on index 2.
        @(negedge clk);
        pulse_reset();
        req = 4'b0100; upd = 1; last = 0; fix = 0;
        @(negedge clk);
        req = 4'b0110; upd = 0;
        #1;
        check("lock before arst", 32'(l1), 32'd1);
        check("grant before arst", 32'(g1), 32'(4'b0100));
        arst = 1'b0;
        #1;
        check("lock during arst", 32'(l1), 32'd0);
        check("grant during arst", 32'(g1), 32'(4'b0010));
        check("idx during arst", 32'(gi1), 32'd1);
        $display("[TB] arst mid-packet grant=%b locked=%b", g1, l1);
        arst = 1'b1;

        // Random stimulus against the reference model, both weights.
        @(negedge clk);
        pulse_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
                model_reset();
            end
            req  = 4'($urandom_range(0, 15));
            upd  = ($urandom_range(0, 9) < 7);
            last = ($urandom_range(0, 9) < 4);
            fix  = ($urandom_range(0, 9) == 0);
            #1;
            e1 = model_grant(0, req, fix);
            e2 = model_grant(1, req, fix);
            check($sformatf("rnd%0d w1 grant", c), 32'(g1), (e1 < 0) ? 32'd0 : (32'd1 << e1));
            check($sformatf("rnd%0d w1 idx", c),   32'(gi1), (e1 < 0) ? 32'd0 : 32'(e1));
            check($sformatf("rnd%0d w1 lock", c),  32'(l1), 32'(m_locked[0]));
            check($sformatf("rnd%0d w2 grant", c), 32'(g2), (e2 < 0) ? 32'd0 : (32'd1 << e2));
            check($sformatf("rnd%0d w2 idx", c),   32'(gi2), (e2 < 0) ? 32'd0 : 32'(e2));
            check($sformatf("rnd%0d w2 lock", c),  32'(l2), 32'(m_locked[1]));
            if (c % 100 == 0)
                $display("[TB] rnd%0d req=%b upd=%b last=%b fix=%b g1=%b g2=%b", c, req, upd, last, fix, g1, g2);
            model_step(0, req, upd, last, fix);
            model_step(1, req, upd, last, fix);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
